// File: rtl/xd_pacer.sv
// Source-domain event pacer: queues evt pulses and issues them one at a time as
// single-cycle flag pulses, spaced (and optionally ack-gated) for the toggle CDC.
module xd_pacer #(
  parameter int CNTW    = 4,
  parameter int GAP     = 4,
  parameter int ACK_EN  = 0,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            evt,
  input  logic            ack,
  input  logic            clr,
  output logic            flag_src,
  output logic [CNTW-1:0] pending,
  output logic            busy,
  output logic            overflow,
  output logic            timeout_err
);

  localparam int WCW = (ACK_EN != 0) ? $clog2(TIMEOUT + 1) : $clog2(GAP + 1);
  localparam logic [CNTW-1:0] PEND_MAX = {CNTW{1'b1}};
  localparam logic [WCW-1:0]  GAP_LAST = WCW'(GAP - 1);
  localparam logic [WCW-1:0]  TO_LAST  = WCW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t          state_reg, state_next;
  logic [WCW-1:0]  wcnt_reg, wcnt_next;
  logic [CNTW-1:0] pend_reg, pend_next;
  logic            ack_seen_reg, ack_seen_next;
  logic            flag_reg, flag_next;
  logic            ovf_reg, ovf_next;
  logic            terr_reg, terr_next;
  logic            dispatch, ovf_set, terr_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      wcnt_reg     <= '0;
      pend_reg     <= '0;
      ack_seen_reg <= 1'b0;
      flag_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
      terr_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wcnt_reg     <= wcnt_next;
      pend_reg     <= pend_next;
      ack_seen_reg <= ack_seen_next;
      flag_reg     <= flag_next;
      ovf_reg      <= ovf_next;
      terr_reg     <= terr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wcnt_next     = wcnt_reg;
    ack_seen_next = ack_seen_reg;
    flag_next     = 1'b0;
    dispatch      = 1'b0;
    terr_set      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (pend_reg != '0) begin
          state_next = SEND;
          flag_next  = 1'b1;
          dispatch   = 1'b1;
        end
      end
      SEND: begin
        state_next    = WAIT;
        wcnt_next     = '0;
        ack_seen_next = 1'b0;
      end
      WAIT: begin
        if (ACK_EN == 0) begin
          if (wcnt_reg == GAP_LAST) state_next = IDLE;
          else                      wcnt_next  = wcnt_reg + 1'b1;
        end else begin
          ack_seen_next = ack_seen_reg | ack;
          // A late ack on the final timeout cycle still counts as a clean exit.
          if ((ack_seen_reg || ack) && (wcnt_reg >= GAP_LAST)) begin
            state_next = IDLE;
          end else if (wcnt_reg == TO_LAST) begin
            state_next = IDLE;
            terr_set   = 1'b1;
          end else begin
            wcnt_next = wcnt_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Simultaneous arrival and dispatch cancel, so a full queue only drops
    // an event when nothing is leaving that cycle.
    pend_next = pend_reg;
    ovf_set   = 1'b0;
    if (evt && !dispatch) begin
      if (pend_reg == PEND_MAX) ovf_set   = 1'b1;
      else                      pend_next = pend_reg + 1'b1;
    end else if (!evt && dispatch) begin
      pend_next = pend_reg - 1'b1;
    end

    ovf_next  = ovf_set  ? 1'b1 : (clr ? 1'b0 : ovf_reg);
    terr_next = terr_set ? 1'b1 : (clr ? 1'b0 : terr_reg);
  end

  assign flag_src    = flag_reg;
  assign pending     = pend_reg;
  assign busy        = (state_reg != IDLE) || (pend_reg != '0);
  assign overflow    = ovf_reg;
  assign timeout_err = terr_reg;

endmodule
